// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer for the radix-2 NTT core: read/twiddle address generation per stage,
// PE-latency write replay, and inter-stage pipeline drain.
module ntt_stage_sequencer #(
   parameter int unsigned RING_SIZE  = 256,
   parameter int unsigned PE_LATENCY = 3,
   localparam int unsigned ADDR_W    = $clog2(RING_SIZE / 2),
   localparam int unsigned TW_W      = $clog2(RING_SIZE),
   localparam int unsigned STAGE_W   = ($clog2(RING_SIZE) > 1) ? $clog2($clog2(RING_SIZE)) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [TW_W-1:0]    tw_addr,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [STAGE_W-1:0] stage,
   output logic               sel_a,
   output logic               sel_b,
   output logic               last_stage,
   output logic               busy,
   output logic               done
);

   localparam int unsigned H       = RING_SIZE / 2;
   localparam int unsigned LOGH    = $clog2(H);
   localparam int unsigned STAGES  = $clog2(RING_SIZE);
   localparam int unsigned DRAIN_W = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t               state_q, state_n;
   logic [ADDR_W-1:0]    k_q, k_n;
   logic [STAGE_W-1:0]   stage_q, stage_n;
   logic [DRAIN_W-1:0]   drain_q, drain_n;
   logic                 run_n, busy_n, last_n;
   logic [TW_W-1:0]      tw_base, tw_off, tw_n;

   logic [PE_LATENCY-1:0] dl_en;
   logic [ADDR_W-1:0]     dl_addr [PE_LATENCY];

   // Next-state logic and next values of the registered outputs
   always_comb begin
      state_n = state_q;
      k_n     = k_q;
      stage_n = stage_q;
      drain_n = drain_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               k_n     = '0;
               stage_n = '0;
            end
         end
         RUN: begin
            if (k_q == ADDR_W'(H - 1)) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               k_n = k_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_W'(PE_LATENCY - 1)) begin
               if (stage_q == STAGE_W'(STAGES - 1)) begin
                  state_n = FIN;
               end else begin
                  state_n = RUN;
                  stage_n = stage_q + STAGE_W'(1);
                  k_n     = '0;
               end
            end else begin
               drain_n = drain_q + DRAIN_W'(1);
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      run_n   = (state_n == RUN);
      busy_n  = run_n || (state_n == DRAIN);
      last_n  = busy_n && (stage_n == STAGE_W'(STAGES - 1));
      // tw = (2^s - 1) + (k >> (LOGH - s)); peaks at N-2, so TW_W bits suffice
      tw_base = (TW_W'(1) << stage_n) - TW_W'(1);
      tw_off  = TW_W'(k_n) >> (32'(LOGH) - 32'(stage_n));
      tw_n    = run_n ? (tw_base + tw_off) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         stage_q    <= '0;
         drain_q    <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         tw_addr    <= '0;
         stage      <= '0;
         sel_a      <= 1'b0;
         sel_b      <= 1'b0;
         last_stage <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dl_en      <= '0;
         for (int i = 0; i < int'(PE_LATENCY); i++) dl_addr[i] <= '0;
      end else begin
         state_q    <= state_n;
         k_q        <= k_n;
         stage_q    <= stage_n;
         drain_q    <= drain_n;
         rd_en      <= run_n;
         rd_addr    <= run_n ? k_n : '0;
         tw_addr    <= tw_n;
         stage      <= busy_n ? stage_n : '0;
         sel_a      <= busy_n & stage_n[0];
         sel_b      <= last_n;
         last_stage <= last_n;
         busy       <= busy_n;
         done       <= (state_n == FIN);
         // Write replay line: each issued read reappears PE_LATENCY cycles later
         dl_en[0]   <= rd_en;
         dl_addr[0] <= rd_addr;
         for (int i = 1; i < int'(PE_LATENCY); i++) begin
            dl_en[i]   <= dl_en[i-1];
            dl_addr[i] <= dl_addr[i-1];
         end
      end
   end

   assign wr_en   = dl_en[PE_LATENCY-1];
   assign wr_addr = dl_addr[PE_LATENCY-1];

endmodule

// File: doc/ntt_stage_sequencer.md
# ntt_stage_sequencer

Sequences the radix-2 NTT core: two half-depth BRAM banks, the two butterfly PEs and the final PE_Tilde pass. It is triggered by the bit-reverse loader's `done` pulse. For each of the log2(RING_SIZE) stages it issues one read per cycle to both banks and the matching twiddle-ROM address. It replays each address as a write after the PE pipeline latency, and drains that pipeline between stages to avoid read-after-write hazards. It replaces the free-running address generator and stage controller pair that sit between the loader and the output reorder stage.

## Interface
Parameters:
- `RING_SIZE`, default 256: transform length N; power of two, at least 4.
- `PE_LATENCY`, default 3: cycles from BRAM read issue to PE result valid at the BRAM write port; at least 1.
- Derived: H = N/2, LOGH = log2(H), STAGES = log2(N), ADDR_W = LOGH, TW_W = log2(N), STAGE_W = max(1, clog2(STAGES)).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse from the bit-reverse loader; accepted only in IDLE.
- `rd_en`  out  1  read issue to both banks.
- `rd_addr`  out  ADDR_W  bank read address.
- `tw_addr`  out  TW_W  twiddle ROM address, aligned with `rd_en`.
- `wr_en`  out  1  write enable to both banks.
- `wr_addr`  out  ADDR_W  bank write address.
- `stage`  out  STAGE_W  current stage index, 0..STAGES-1.
- `sel_a`  out  1  PE operand-routing select; equals `stage[0]` while busy.
- `sel_b`  out  1  PE output select; equals `last_stage`.
- `last_stage`  out  1  high throughout the final stage (RUN and DRAIN); steers PE results into PE_Tilde.
- `busy`  out  1  high from the first read through the end of the final drain.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: issues H reads per stage.
  - DRAIN: lasts PE_LATENCY cycles.
  - FIN: one cycle, asserts `done`.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the read with address H-1.
  - DRAIN→RUN (stage+1) when the drain count expires and stage < STAGES-1.
  - DRAIN→FIN when the drain count expires on the last stage.
  - FIN→IDLE unconditionally.
- Read counter k: 0..H-1, one increment per RUN cycle; `rd_addr` = k; resets to 0 on entering each RUN.
- Twiddle address at stage s: `tw_addr` = (2^s − 1) + (k >> (LOGH − s)), computed at TW_W bits without overflow. The maximum value is N−2, so the ROM depth is N−1.
- Write path: a PE_LATENCY-deep shift register carries {rd_en, rd_addr}. `wr_en`/`wr_addr` are its output, so every read produces exactly one write to the same address PE_LATENCY cycles later.
- `start` is ignored in RUN, DRAIN and FIN. A simultaneous `reset` and `start` results in reset.
- Reset values: all outputs 0, state IDLE, and the delay line fully cleared. A reset mid-transform therefore emits no stray `wr_en` afterwards.
- In IDLE and FIN: `rd_en`=0, `rd_addr`=0, `tw_addr`=0, `stage`=0, `sel_a`=`sel_b`=`last_stage`=0.

## Timing
- `start` sampled at cycle t: first `rd_en` (addr 0) at t+1. All outputs are registered.
- Stage s reads occupy cycles t+1+s·(H+PE_LATENCY) through t+s·(H+PE_LATENCY)+H, one per cycle with no gaps.
- Write for the read at cycle c occurs at c+PE_LATENCY. The last write of a stage lands the cycle before the next stage's first read.
- Drain occupies PE_LATENCY cycles per stage. The final stage is drained too, so PE_Tilde receives all of its inputs.
- `done` is asserted at t+1+STAGES·(H+PE_LATENCY), and `busy` is low in that cycle. `busy` is high on every cycle from t+1 through t+STAGES·(H+PE_LATENCY).
- Earliest accepted re-`start`: the cycle after `done`.

## Test plan
- Full run, N=16, PE_LATENCY=3, `start` at cycle 0:
  - reads on cycles 1–8, 12–19, 23–30, 34–41, with `rd_addr` 0..7 each stage;
  - writes on cycles 4–11, 15–22, 26–33, 37–44, with the same addresses;
  - `done` at cycle 45 only; `busy` high on cycles 1–44.
- Twiddle check, same run:
  - stage 0: `tw_addr` all 0;
  - stage 1: 1,1,1,1,2,2,2,2;
  - stage 2: 3,3,4,4,5,5,6,6;
  - stage 3: 7..14.
- Stage flags, same run: `stage` and `sel_a` follow 0/1/2/3 and 0/1/0/1; `last_stage`=`sel_b`=1 exactly on cycles 34–44.
- `start` pulses at cycles 5, 30 and 45 during a run: no effect. Timeline identical to the full-run scenario, and no second run begins.
- `reset` at cycle 20 (mid stage 1): from cycle 21, all outputs are 0 and `wr_en` stays 0. A `start` at cycle 25 gives first read at 26 and `done` at 70.
- Back-to-back: `start` at 0 and 46 (the cycle after `done`): the second run's first read is at 47 and its `done` at 91.
